// File: rtl/psr_pkg.sv
// Shared constants for the processor-state register block: op3 codes,
// PSR bit positions and the window-mask helper.
package psr_pkg;

  localparam logic [1:0] OP_FMT3 = 2'b10;

  localparam logic [5:0] OP3_SAVE    = 6'b111100;
  localparam logic [5:0] OP3_RESTORE = 6'b111101;
  localparam logic [5:0] OP3_WRPSR   = 6'b110001;
  localparam logic [5:0] OP3_WRWIM   = 6'b110010;
  localparam logic [5:0] OP3_RETT    = 6'b111001;

  localparam int PSR_N_BIT   = 23;
  localparam int PSR_C_BIT   = 20;
  localparam int PSR_S_BIT   = 7;
  localparam int PSR_PS_BIT  = 6;
  localparam int PSR_ET_BIT  = 5;
  localparam int PSR_CWP_MSB = 4;
  localparam int PSR_CWP_LSB = 0;

  // Ones in the low nw bit positions, zero above.
  function automatic logic [31:0] wim_mask(input int nw);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (i < nw) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/psr_icc_unit_cwp_step.sv
// cwp_step: combinational modular +1/-1 of a window pointer for NWINDOWS windows.
module cwp_step #(
  parameter int NWINDOWS = 4
) (
  input  logic [4:0] cwp_i,
  input  logic       inc_i,
  output logic [4:0] cwp_o
);

  localparam logic [4:0] LAST = 5'(NWINDOWS - 1);

  // Increment wraps LAST->0, decrement wraps 0->LAST.
  always_comb begin
    if (inc_i) begin
      if (cwp_i >= LAST) begin
        cwp_o = 5'd0;
      end else begin
        cwp_o = cwp_i + 5'd1;
      end
    end else begin
      if (cwp_i == 5'd0) begin
        cwp_o = LAST;
      end else begin
        cwp_o = cwp_i - 5'd1;
      end
    end
  end

endmodule

// File: rtl/psr_icc_unit.sv
// SPARC processor-state register block (icc, CWP, WIM, S/PS/ET).
// Define WIM_CHECK_EN to enable the SAVE/RESTORE window overflow/underflow check.
module psr_icc_unit
  import psr_pkg::*;
#(
  parameter int NWINDOWS = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        Exec,
  input  logic        ALU_N,
  input  logic        ALU_Z,
  input  logic        ALU_V,
  input  logic        ALU_C,
  input  logic [31:0] WrData,
  input  logic        TrapEnter,
  output logic        N,
  output logic        Z,
  output logic        V,
  output logic        C,
  output logic [4:0]  CWP,
  output logic [31:0] WIM,
  output logic        S,
  output logic        PS,
  output logic        ET,
  output logic [31:0] PSR,
  output logic        WinOvf,
  output logic        WinUnf,
  output logic        IllegalWr
);

  localparam logic [31:0] WIM_MASK = wim_mask(NWINDOWS);
  localparam logic [5:0]  NW6      = 6'(NWINDOWS);

  logic [3:0]  nzvc_q, nzvc_d;
  logic [4:0]  cwp_q, cwp_d;
  logic [31:0] wim_q, wim_d;
  logic        s_q, s_d, ps_q, ps_d, et_q, et_d;
  logic        ovf_q, ovf_d, unf_q, unf_d, ill_q, ill_d;

  logic [4:0]  cwp_dec_s, cwp_inc_s;
  logic [5:0]  op3_s;
  logic        fmt3_s;
  logic        unused_ir_s;

  assign op3_s       = IR[24:19];
  assign fmt3_s      = Exec && (IR[31:30] == OP_FMT3);
  assign unused_ir_s = ^{IR[29:25], IR[18:0]};

  cwp_step #(.NWINDOWS(NWINDOWS)) u_step_dec (
    .cwp_i (cwp_q),
    .inc_i (1'b0),
    .cwp_o (cwp_dec_s)
  );

  cwp_step #(.NWINDOWS(NWINDOWS)) u_step_inc (
    .cwp_i (cwp_q),
    .inc_i (1'b1),
    .cwp_o (cwp_inc_s)
  );

  // State register; pulses default low every cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      nzvc_q <= 4'd0;
      cwp_q  <= 5'd0;
      wim_q  <= 32'd0;
      s_q    <= 1'b1;
      ps_q   <= 1'b0;
      et_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      nzvc_q <= nzvc_d;
      cwp_q  <= cwp_d;
      wim_q  <= wim_d;
      s_q    <= s_d;
      ps_q   <= ps_d;
      et_q   <= et_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      ill_q  <= ill_d;
    end
  end

  // Next-state decode; trap entry takes priority and suppresses IR entirely.
  always_comb begin
    nzvc_d = nzvc_q;
    cwp_d  = cwp_q;
    wim_d  = wim_q;
    s_d    = s_q;
    ps_d   = ps_q;
    et_d   = et_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    ill_d  = 1'b0;
    if (TrapEnter) begin
      et_d  = 1'b0;
      ps_d  = s_q;
      s_d   = 1'b1;
      cwp_d = cwp_dec_s;
    end else if (fmt3_s) begin
      if (op3_s[5:4] == 2'b01) begin
        nzvc_d = {ALU_N, ALU_Z, ALU_V, ALU_C};
      end else begin
        case (op3_s)
          OP3_SAVE: begin
`ifdef WIM_CHECK_EN
            if (wim_q[cwp_dec_s]) begin
              ovf_d = 1'b1;
            end else begin
              cwp_d = cwp_dec_s;
            end
`else
            cwp_d = cwp_dec_s;
`endif
          end
          OP3_RESTORE: begin
`ifdef WIM_CHECK_EN
            if (wim_q[cwp_inc_s]) begin
              unf_d = 1'b1;
            end else begin
              cwp_d = cwp_inc_s;
            end
`else
            cwp_d = cwp_inc_s;
`endif
          end
          OP3_WRPSR: begin
            if ({1'b0, WrData[4:0]} >= NW6) begin
              ill_d = 1'b1;
            end else begin
              nzvc_d = WrData[PSR_N_BIT:PSR_C_BIT];
              s_d    = WrData[PSR_S_BIT];
              ps_d   = WrData[PSR_PS_BIT];
              et_d   = WrData[PSR_ET_BIT];
              cwp_d  = WrData[PSR_CWP_MSB:PSR_CWP_LSB];
            end
          end
          OP3_WRWIM: begin
            wim_d = WrData & WIM_MASK;
          end
          OP3_RETT: begin
            cwp_d = cwp_inc_s;
            s_d   = ps_q;
            et_d  = 1'b1;
          end
          default: begin
            cwp_d = cwp_q;
          end
        endcase
      end
    end else begin
      cwp_d = cwp_q;
    end
  end

  // Assembled PSR view straight from the registers.
  always_comb begin
    PSR = 32'd0;
    PSR[PSR_N_BIT:PSR_C_BIT]     = nzvc_q;
    PSR[PSR_S_BIT]               = s_q;
    PSR[PSR_PS_BIT]              = ps_q;
    PSR[PSR_ET_BIT]              = et_q;
    PSR[PSR_CWP_MSB:PSR_CWP_LSB] = cwp_q;
  end

  assign {N, Z, V, C} = nzvc_q;
  assign CWP          = cwp_q;
  assign WIM          = wim_q;
  assign S            = s_q;
  assign PS           = ps_q;
  assign ET           = et_q;
  assign IllegalWr    = ill_q;
`ifdef WIM_CHECK_EN
  assign WinOvf       = ovf_q;
  assign WinUnf       = unf_q;
`else
  assign WinOvf       = 1'b0;
  assign WinUnf       = 1'b0;
`endif

endmodule

// File: tb/tb_psr_icc_unit.sv
// Directed bench for psr_icc_unit with a per-cycle reference model.
module tb_psr_icc_unit;

  localparam int NW = 4;
`ifdef WIM_CHECK_EN
  localparam bit WIM_CHK = 1'b1;
`else
  localparam bit WIM_CHK = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR = 32'd0;
  logic        Exec = 1'b0;
  logic        ALU_N = 1'b0, ALU_Z = 1'b0, ALU_V = 1'b0, ALU_C = 1'b0;
  logic [31:0] WrData = 32'd0;
  logic        TrapEnter = 1'b0;
  logic        N, Z, V, C, S, PS, ET, WinOvf, WinUnf, IllegalWr;
  logic [4:0]  CWP;
  logic [31:0] WIM, PSR;

  int errors = 0;
  int checks = 0;
  bit run = 1'b0;

  psr_icc_unit #(.NWINDOWS(NW)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Exec(Exec),
    .ALU_N(ALU_N), .ALU_Z(ALU_Z), .ALU_V(ALU_V), .ALU_C(ALU_C),
    .WrData(WrData), .TrapEnter(TrapEnter),
    .N(N), .Z(Z), .V(V), .C(C), .CWP(CWP), .WIM(WIM),
    .S(S), .PS(PS), .ET(ET), .PSR(PSR),
    .WinOvf(WinOvf), .WinUnf(WinUnf), .IllegalWr(IllegalWr)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmt3(input logic [5:0] op3);
    return {2'b10, 5'd0, op3, 19'd0};
  endfunction

  // Reference model: architectural state as plain integers.
  logic [3:0]  m_nzvc = 4'd0;
  int          m_cwp = 0;
  logic [31:0] m_wim = 32'd0;
  logic        m_s = 1'b1, m_ps = 1'b0, m_et = 1'b0;
  logic        m_ovf = 1'b0, m_unf = 1'b0, m_ill = 1'b0;

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_nzvc <= 4'd0; m_cwp <= 0; m_wim <= 32'd0;
      m_s <= 1'b1; m_ps <= 1'b0; m_et <= 1'b0;
      m_ovf <= 1'b0; m_unf <= 1'b0; m_ill <= 1'b0;
    end else begin
      m_ovf <= 1'b0; m_unf <= 1'b0; m_ill <= 1'b0;
      if (TrapEnter) begin
        m_et <= 1'b0; m_ps <= m_s; m_s <= 1'b1;
        m_cwp <= (m_cwp + NW - 1) % NW;
      end else if (Exec && IR[31:30] == 2'b10) begin
        if (IR[24:23] == 2'b01) begin
          m_nzvc <= {ALU_N, ALU_Z, ALU_V, ALU_C};
        end else if (IR[24:19] == 6'b111100) begin
          if (WIM_CHK && m_wim[(m_cwp + NW - 1) % NW]) m_ovf <= 1'b1;
          else m_cwp <= (m_cwp + NW - 1) % NW;
        end else if (IR[24:19] == 6'b111101) begin
          if (WIM_CHK && m_wim[(m_cwp + 1) % NW]) m_unf <= 1'b1;
          else m_cwp <= (m_cwp + 1) % NW;
        end else if (IR[24:19] == 6'b110001) begin
          if (int'(WrData[4:0]) >= NW) m_ill <= 1'b1;
          else begin
            m_nzvc <= WrData[23:20]; m_s <= WrData[7]; m_ps <= WrData[6];
            m_et <= WrData[5]; m_cwp <= int'(WrData[4:0]);
          end
        end else if (IR[24:19] == 6'b110010) begin
          m_wim <= WrData & 32'((64'd1 << NW) - 64'd1);
        end else if (IR[24:19] == 6'b111001) begin
          m_cwp <= (m_cwp + 1) % NW; m_s <= m_ps; m_et <= 1'b1;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge Clock) begin
    if (run) begin
      chk("m_nzvc", {N, Z, V, C}, m_nzvc);
      chk("m_cwp", CWP, 32'(m_cwp));
      chk("m_wim", WIM, m_wim);
      chk("m_s_ps_et", {S, PS, ET}, {m_s, m_ps, m_et});
      chk("m_psr", PSR, {8'd0, m_nzvc, 12'd0, m_s, m_ps, m_et, 5'(m_cwp)});
      chk("m_pulses", {WinOvf, WinUnf, IllegalWr}, {m_ovf, m_unf, m_ill});
    end
  end

  task automatic op(input logic [31:0] ir, input logic [31:0] wd, input logic [3:0] fl,
                    input bit ex, input bit tr);
    IR = ir; WrData = wd; {ALU_N, ALU_Z, ALU_V, ALU_C} = fl;
    Exec = ex; TrapEnter = tr;
    @(negedge Clock);
    Exec = 1'b0; TrapEnter = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    run = 1'b1;
    chk("reset_psr", PSR, 32'h0000_0080);
    chk("reset_pulses", {WinOvf, WinUnf, IllegalWr}, 32'd0);

    op(32'h8080_0002, 32'd0, 4'b1010, 1'b1, 1'b0);
    chk("addcc_psr", PSR, 32'h00A0_0080);
    op(32'h8000_0002, 32'd0, 4'b0101, 1'b1, 1'b0);
    chk("add_nocc", {N, Z, V, C}, 32'b1010);

    op(fmt3(6'b110010), 32'hFFFF_FFFF, 4'd0, 1'b1, 1'b0);
    chk("wrwim_mask", WIM, 32'h0000_000F);
    op(fmt3(6'b110010), 32'h0000_0008, 4'd0, 1'b1, 1'b0);
    op(fmt3(6'b111100), 32'd0, 4'd0, 1'b1, 1'b0);
    chk("save_wrap_cwp", CWP, WIM_CHK ? 32'd0 : 32'd3);
    chk("save_ovf", WinOvf, WIM_CHK ? 32'd1 : 32'd0);
    @(negedge Clock);
    chk("ovf_one_cycle", WinOvf, 32'd0);

    op(fmt3(6'b110001), 32'h0000_0083, 4'd0, 1'b1, 1'b0);
    op(fmt3(6'b110010), 32'h0000_0001, 4'd0, 1'b1, 1'b0);
    op(fmt3(6'b111101), 32'd0, 4'd0, 1'b1, 1'b0);
    chk("restore_cwp", CWP, WIM_CHK ? 32'd3 : 32'd0);
    chk("restore_unf", WinUnf, WIM_CHK ? 32'd1 : 32'd0);

    op(fmt3(6'b110010), 32'd0, 4'd0, 1'b1, 1'b0);
    op(fmt3(6'b110001), 32'h0000_0080, 4'd0, 1'b1, 1'b0);
    op(fmt3(6'b111100), 32'd0, 4'd0, 1'b1, 1'b0);
    chk("save_cwp3", CWP, 32'd3);
    op(fmt3(6'b111100), 32'd0, 4'd0, 1'b1, 1'b0);
    chk("save_b2b_cwp2", CWP, 32'd2);

    op(fmt3(6'b110001), 32'h00F0_00A2, 4'd0, 1'b1, 1'b0);
    chk("wrpsr_psr", PSR, 32'h00F0_00A2);
    chk("wrpsr_s_et", {S, ET}, 32'b11);
    op(fmt3(6'b110001), 32'h0000_0005, 4'd0, 1'b1, 1'b0);
    chk("wrpsr_illegal", IllegalWr, 32'd1);
    chk("wrpsr_illegal_psr", PSR, 32'h00F0_00A2);

    op(fmt3(6'b110001), 32'h00F0_0001, 4'd0, 1'b1, 1'b0);
    op(fmt3(6'b110010), 32'h0000_0001, 4'd0, 1'b1, 1'b0);
    op(fmt3(6'b111100), 32'd0, 4'b1111, 1'b1, 1'b1);
    chk("trap_psr", PSR, 32'h00F0_0080);
    chk("trap_no_ovf", WinOvf, 32'd0);
    op(fmt3(6'b111001), 32'd0, 4'd0, 1'b1, 1'b0);
    chk("rett_psr", PSR, 32'h00F0_0021);

    op({2'b01, 5'd0, 6'b111100, 19'd0}, 32'd0, 4'd0, 1'b1, 1'b0);
    op(fmt3(6'b111100), 32'd0, 4'd0, 1'b0, 1'b0);
    chk("no_op_psr", PSR, 32'h00F0_0021);

    op(fmt3(6'b110001), 32'h0000_0003, 4'd0, 1'b1, 1'b0);
    chk("pre_reset_psr", PSR, 32'h0000_0003);
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_psr", PSR, 32'h0000_0080);
    chk("async_reset_wim", WIM, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("post_reset_psr", PSR, 32'h0000_0080);

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
